pc_sequencer: RTL

Run-control and program-counter sequencer for the single-cycle 9-bit processor. It accepts a start request, loads the program entry address and steps the PC once per cycle. It resolves branches through a 4-entry signed offset table indexed by the decoder's `how_high` field, owns the shift-carry flag that the decoder consumes, and reports completion on a halt. It sits between the testbench/top-level start/done handshake and the instruction ROM, control decoder and register file.

---
 rtl/pc_sequencer_if.sv | 24 ++
 rtl/pc_sequencer.sv | 69 ++++++
 2 files changed

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: run-control, decoder and PC signals between the sequencer and its surroundings.
interface pc_sequencer_if #(parameter int PCW = 10);
  logic           start;
  logic [PCW-1:0] start_addr;
  logic           branch;
  logic [1:0]     how_high;
  logic           halt;
  logic           sc_en;
  logic           sc_clr;
  logic           sc_in;
  logic [PCW-1:0] pc;
  logic           run;
  logic           sc_o;
  logic           done;
  logic [15:0]    cycle_count;
  modport master (
    output start, start_addr, branch, how_high, halt, sc_en, sc_clr, sc_in,
    input  pc, run, sc_o, done, cycle_count
  );
  modport slave (
    input  start, start_addr, branch, how_high, halt, sc_en, sc_clr, sc_in,
    output pc, run, sc_o, done, cycle_count
  );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: start/done run control, PC stepping with table branches, shift-carry flag and instruction count.
module pc_sequencer #(
  parameter int PCW     = 10,
  parameter int BR_OFF0 = -4,
  parameter int BR_OFF1 = -16,
  parameter int BR_OFF2 = 8,
  parameter int BR_OFF3 = 32
) (
  input logic clk,
  input logic reset_n,
  pc_sequencer_if.slave s
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
  localparam logic [PCW-1:0] OFF0 = PCW'(BR_OFF0);
  localparam logic [PCW-1:0] OFF1 = PCW'(BR_OFF1);
  localparam logic [PCW-1:0] OFF2 = PCW'(BR_OFF2);
  localparam logic [PCW-1:0] OFF3 = PCW'(BR_OFF3);
  state_t         state_q, state_d;
  logic [PCW-1:0] pc_q, pc_d, off;
  logic           sc_q, sc_d, done_q, done_d;
  logic [15:0]    cnt_q, cnt_d;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      sc_q    <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      sc_q    <= sc_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    sc_d    = sc_q;
    done_d  = done_q;
    cnt_d   = cnt_q;
    off     = s.how_high[1] ? (s.how_high[0] ? OFF3 : OFF2) : (s.how_high[0] ? OFF1 : OFF0);
    case (state_q)
      IDLE, DONE: state_d = s.start ? LOAD : state_q;
      LOAD: begin
        state_d = RUN;
        pc_d    = s.start_addr;
        sc_d    = 1'b0;
        done_d  = 1'b0;
        cnt_d   = '0;
      end
      RUN: begin
        state_d = s.halt ? DONE : RUN;
        done_d  = s.halt;
        pc_d    = s.halt ? pc_q : pc_q + (s.branch ? off : PCW'(1));
        sc_d    = s.sc_en ? s.sc_in : (s.sc_clr ? 1'b0 : sc_q);
        cnt_d   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  // run follows the state register, so an async reset removes the commit enable at once
  assign s.run         = (state_q == RUN) && !s.halt;
  assign s.pc          = pc_q;
  assign s.sc_o        = sc_q;
  assign s.done        = done_q;
  assign s.cycle_count = cnt_q;
endmodule
